// File: rtl/vlan_demux_stream.sv
// Steers AXI4-Stream packets to one of NUM_VSWITCH outputs by 802.1Q VID,
// dropping untagged or out-of-range packets through a single registered output entry.
module vlan_demux_stream #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          NUM_VSWITCH          = 4,
    parameter logic [11:0] VID_BASE             = 12'h001,
    parameter logic [15:0] TPID_MATCH           = 16'h0081,
    parameter int          CNT_WIDTH            = 32
) (
    input  logic                                        axis_aclk,
    input  logic                                        axis_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]              s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]            s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]             s_axis_tuser,
    input  logic                                        s_axis_tvalid,
    input  logic                                        s_axis_tlast,
    output logic                                        s_axis_tready,
    output logic [NUM_VSWITCH*C_S_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [NUM_VSWITCH*C_S_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [NUM_VSWITCH*C_S_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [NUM_VSWITCH-1:0]                      m_axis_tvalid,
    output logic [NUM_VSWITCH-1:0]                      m_axis_tlast,
    input  logic [NUM_VSWITCH-1:0]                      m_axis_tready,
    output logic [CNT_WIDTH-1:0]                        drop_count
);
    localparam int          DW       = C_S_AXIS_DATA_WIDTH;
    localparam int          KW       = C_S_AXIS_DATA_WIDTH / 8;
    localparam int          UW       = C_S_AXIS_TUSER_WIDTH;
    localparam int          SEL_W    = (NUM_VSWITCH > 1) ? $clog2(NUM_VSWITCH) : 1;
    localparam logic [11:0] NUM_VS12 = 12'(NUM_VSWITCH);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t             state, state_nxt;
    logic [DW-1:0]      data_q;
    logic [KW-1:0]      keep_q;
    logic [UW-1:0]      user_q;
    logic               last_q;
    logic [SEL_W-1:0]   sel_q;
    logic               full_q;

    logic [15:0]        tpid;
    logic [11:0]        vid;
    logic [11:0]        vid_off;
    logic               hit;
    logic [SEL_W-1:0]   ch;
    logic               can_load;
    logic               rdy;
    logic               load;
    logic [SEL_W-1:0]   load_sel;
    logic               drop_inc;

    // Header decode is only meaningful on the first beat; the FSM decides when to use it.
    assign tpid     = s_axis_tdata[111:96];
    assign vid      = {s_axis_tdata[115:112], s_axis_tdata[127:120]};
    assign vid_off  = vid - VID_BASE;
    assign hit      = (tpid == TPID_MATCH) && (vid >= VID_BASE) && (vid_off < NUM_VS12);
    assign ch       = vid_off[SEL_W-1:0];
    assign can_load = !full_q || m_axis_tready[sel_q];

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        load      = 1'b0;
        load_sel  = sel_q;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                rdy = can_load;
                if (s_axis_tvalid && can_load) begin
                    if (hit) begin
                        load     = 1'b1;
                        load_sel = ch;
                        if (!s_axis_tlast) state_nxt = FWD;
                    end else begin
                        drop_inc = 1'b1;
                        if (!s_axis_tlast) state_nxt = DROP;
                    end
                end
            end
            FWD: begin
                rdy = can_load;
                if (s_axis_tvalid && can_load) begin
                    load = 1'b1;
                    if (s_axis_tlast) state_nxt = IDLE;
                end
            end
            DROP: begin
                rdy = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is forced low while reset is held so nothing looks accepted upstream.
    assign s_axis_tready = rdy && axis_resetn;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state  <= IDLE;
            data_q <= '0;
            keep_q <= '0;
            user_q <= '0;
            last_q <= 1'b0;
            sel_q  <= '0;
            full_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                data_q <= s_axis_tdata;
                keep_q <= s_axis_tkeep;
                user_q <= s_axis_tuser;
                last_q <= s_axis_tlast;
                sel_q  <= load_sel;
                full_q <= 1'b1;
            end else if (full_q && m_axis_tready[sel_q]) begin
                full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn)
            drop_count <= '0;
        else if (drop_inc && (drop_count != {CNT_WIDTH{1'b1}}))
            drop_count <= drop_count + CNT_WIDTH'(1);
    end

    // Payload is broadcast; only the selected channel's tvalid qualifies it.
    for (genvar k = 0; k < NUM_VSWITCH; k++) begin : g_ch
        assign m_axis_tdata[k*DW +: DW] = data_q;
        assign m_axis_tkeep[k*KW +: KW] = keep_q;
        assign m_axis_tuser[k*UW +: UW] = user_q;
        assign m_axis_tvalid[k]         = full_q && (sel_q == SEL_W'(k));
        assign m_axis_tlast[k]          = full_q && (sel_q == SEL_W'(k)) && last_q;
    end

endmodule

// File: tb/tb_vlan_demux_stream.sv
// Scoreboard bench for vlan_demux_stream: the driver models the demux and pushes
// expected beats; the output monitor pops and compares them per channel.
module tb_vlan_demux_stream;
    localparam int DW  = 256;
    localparam int KW  = 32;
    localparam int UW  = 128;
    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int CNT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     s_tdata = '0;
    logic [KW-1:0]     s_tkeep = '0;
    logic [UW-1:0]     s_tuser = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tlast = 1'b0;
    logic              s_tready;
    logic [N*DW-1:0]   m_tdata;
    logic [N*KW-1:0]   m_tkeep;
    logic [N*UW-1:0]   m_tuser;
    logic [N-1:0]      m_tvalid;
    logic [N-1:0]      m_tlast;
    logic [N-1:0]      m_tready = '1;
    logic [CW-1:0]     drop_count;

    vlan_demux_stream #(.CNT_WIDTH(CW)) dut (
        .axis_aclk(clk), .axis_resetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        int            acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_drops = 0;
    bit   in_pkt = 0;
    bit   fwd = 0;
    int   cur_ch = 0;
    bit   head_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [DW-1:0] mk_hdr(input logic [15:0] tp, input logic [11:0] vd);
        logic [DW-1:0] d;
        d = rnd256();
        d[111:96]  = tp;
        d[115:112] = vd[11:8];
        d[127:120] = vd[7:0];
        return d;
    endfunction

    function automatic void reset_model();
        sb.delete();
        in_pkt    = 0;
        fwd       = 0;
        exp_drops = 0;
        head_seen = 0;
    endfunction

    // Drives one beat at a negedge, holds it until accepted, then updates the model.
    task automatic send_beat(input logic [DW-1:0] d, input logic lst, output int waited);
        logic          acc;
        logic [15:0]   tp;
        logic [11:0]   vd;
        exp_t          e;
        @(negedge clk);
        s_tdata  = d;
        s_tkeep  = $urandom;
        s_tuser  = {$urandom, $urandom, $urandom, $urandom};
        s_tlast  = lst;
        s_tvalid = 1'b1;
        waited   = 0;
        acc      = 1'b0;
        while (!acc && waited < 100) begin
            #1 acc = s_tready;
            @(posedge clk);
            #1;
            if (!acc) begin
                waited++;
                @(negedge clk);
            end
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: beat not accepted after %0d cycles, required acceptance", waited);
        end else begin
            if (!in_pkt) begin
                tp = d[111:96];
                vd = {d[115:112], d[127:120]};
                fwd = (tp == 16'h0081) && (vd >= 12'h001) && (vd <= 12'h004);
                cur_ch = int'(vd) - 1;
                if (!fwd && exp_drops < CNT_MAX) exp_drops++;
            end
            if (fwd) begin
                e.ch = cur_ch; e.data = d; e.keep = s_tkeep; e.user = s_tuser;
                e.last = lst; e.acc_cyc = cyc;
                sb.push_back(e);
            end
            in_pkt = !lst;
        end
        s_tvalid = 1'b0;
    endtask

    // Output monitor: one-hot valid, latency, stability under stall, beat contents.
    logic [DW-1:0] prev_data;
    logic [KW-1:0] prev_keep;
    logic [UW-1:0] prev_user;
    logic          prev_last;
    int            prev_k = -1;
    bit            stall_prev = 0;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if ($countones(m_tvalid) > 1) begin
                checks++; errors++;
                $display("FAIL onehot_valid: m_axis_tvalid=%b, required at most one bit", m_tvalid);
            end
            if (stall_prev) begin
                checks++;
                if (m_tvalid[prev_k] !== 1'b1 || m_tdata[prev_k*DW +: DW] !== prev_data ||
                    m_tkeep[prev_k*KW +: KW] !== prev_keep || m_tuser[prev_k*UW +: UW] !== prev_user ||
                    m_tlast[prev_k] !== prev_last) begin
                    errors++;
                    $display("FAIL stall_stable: ch%0d valid=%b data=%h, required held data=%h",
                             prev_k, m_tvalid[prev_k], m_tdata[prev_k*DW +: DW], prev_data);
                end
            end
            stall_prev = 0;
            for (int k = 0; k < N; k++) begin
                if (m_tvalid[k]) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: ch%0d valid with data=%h, required no output", k, m_tdata[k*DW +: DW]);
                    end else begin
                        if (!head_seen) begin
                            checks++;
                            if (cyc != sb[0].acc_cyc) begin
                                errors++;
                                $display("FAIL latency: valid at cycle %0d, required cycle %0d", cyc, sb[0].acc_cyc);
                            end
                            head_seen = 1;
                        end
                        if (m_tready[k]) begin
                            e = sb.pop_front();
                            head_seen = 0;
                            checks++;
                            if (k != e.ch || m_tdata[k*DW +: DW] !== e.data || m_tkeep[k*KW +: KW] !== e.keep ||
                                m_tuser[k*UW +: UW] !== e.user || m_tlast[k] !== e.last) begin
                                errors++;
                                $display("FAIL beat: ch%0d last=%b data=%h, required ch%0d last=%b data=%h",
                                         k, m_tlast[k], m_tdata[k*DW +: DW], e.ch, e.last, e.data);
                            end
                        end else begin
                            stall_prev = 1;
                            prev_k     = k;
                            prev_data  = m_tdata[k*DW +: DW];
                            prev_keep  = m_tkeep[k*KW +: KW];
                            prev_user  = m_tuser[k*UW +: UW];
                            prev_last  = m_tlast[k];
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        reset_model();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== '0 || m_tlast !== '0 || m_tdata !== '0 ||
            m_tkeep !== '0 || m_tuser !== '0 || drop_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs: tready=%b tvalid=%b tlast=%b drop=%0d, required all zero",
                     s_tready, m_tvalid, m_tlast, drop_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_multi_beat();
        int w;
        send_beat(mk_hdr(16'h0081, 12'h003), 1'b0, w);
        send_beat(rnd256(), 1'b0, w);
        send_beat(rnd256(), 1'b1, w);
        repeat (3) @(negedge clk);
        checks++;
        if (drop_count !== 4'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL multi_beat: drop=%0d pending=%0d, required drop=0 pending=0", drop_count, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int w;
        send_beat(mk_hdr(16'h0081, 12'h001), 1'b1, w);
        send_beat(mk_hdr(16'h0081, 12'h004), 1'b1, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL back_to_back: second packet waited %0d cycles, required 0", w);
        end
        send_beat(mk_hdr(16'h0081, 12'h002), 1'b0, w);
        send_beat(rnd256(), 1'b1, w);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_drop();
        int w;
        int stalls = 0;
        send_beat(mk_hdr(16'h0008, 12'h002), 1'b0, w); stalls += w;
        for (int i = 0; i < 3; i++) begin
            send_beat(rnd256(), i == 2, w);
            stalls += w;
        end
        checks++;
        if (stalls != 0 || drop_count !== 4'd1) begin
            errors++;
            $display("FAIL drop_nonvlan: stalls=%0d drop=%0d, required stalls=0 drop=1", stalls, drop_count);
        end
        send_beat(mk_hdr(16'h0081, 12'h005), 1'b0, w);
        send_beat(rnd256(), 1'b1, w);
        checks++;
        if (drop_count !== 4'd2 || drop_count !== CW'(exp_drops)) begin
            errors++;
            $display("FAIL drop_range: drop=%0d, required 2", drop_count);
        end
        send_beat(mk_hdr(16'h0081, 12'h000), 1'b1, w);
        checks++;
        if (drop_count !== 4'd3) begin
            errors++;
            $display("FAIL drop_below_base: drop=%0d, required 3", drop_count);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        fork
            begin
                int w;
                send_beat(mk_hdr(16'h0081, 12'h002), 1'b0, w);
                for (int i = 0; i < 7; i++) send_beat(rnd256(), i == 6, w);
            end
            begin
                repeat (3) @(negedge clk);
                m_tready[1] = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    m_tready[0] = ~m_tready[0];
                    #1;
                    checks++;
                    if (s_tready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_ready: stall cycle %0d s_axis_tready=%b, required 0", i, s_tready);
                    end
                    @(negedge clk);
                end
                m_tready = '1;
            end
        join
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int w;
        send_beat(mk_hdr(16'h0081, 12'h002), 1'b0, w);
        @(negedge clk);
        rst_n = 1'b0;
        reset_model();
        s_tdata  = rnd256();
        s_tvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (s_tready !== 1'b0 || m_tvalid !== '0 || m_tlast !== '0 || m_tdata !== '0 || drop_count !== '0) begin
                errors++;
                $display("FAIL reset_mid: tready=%b tvalid=%b drop=%0d, required all zero", s_tready, m_tvalid, drop_count);
            end
            @(negedge clk);
        end
        rst_n    = 1'b1;
        s_tvalid = 1'b0;
        send_beat(mk_hdr(16'h0081, 12'h004), 1'b0, w);
        send_beat(rnd256(), 1'b1, w);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0 || drop_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_after: pending=%0d drop=%0d, required 0 and 0", sb.size(), drop_count);
        end
    endtask

    task automatic test_saturation();
        int w;
        for (int i = 0; i < 16; i++) begin
            send_beat(mk_hdr(16'h0008, 12'h001), 1'b1, w);
            if (i == 14) begin
                checks++;
                if (drop_count !== 4'hF) begin
                    errors++;
                    $display("FAIL sat_reach: drop=%0d, required 15", drop_count);
                end
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (drop_count !== 4'hF || drop_count !== CW'(exp_drops)) begin
            errors++;
            $display("FAIL sat_hold: drop=%0d, required 15", drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_multi_beat();
        test_back_to_back();
        test_drop();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_drain: pending=%0d, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
